sc_reglane_scroller: RTL and testbench
======================================

SC_REGLANE_SCROLLER -- requirements
Module: sc_reglane_scroller

Interface
REQ-001 Parameter DATAWIDTH, default 16: lane register width; legal range 8 to 32.
REQ-002 Parameter OUTWIDTH, default 8: visible window width; legal range 1 to DATAWIDTH.
REQ-003 Parameter RANDWIDTH, default 4: refill field width; legal range 1 to DATAWIDTH/2.
REQ-004 Parameter DIVWIDTH, default 4: speed divider width.
REQ-005 Parameter DATA_FIXED_INITREG, default 0: value loaded on clear; DATAWIDTH bits.
REQ-006 SC_RegLANE_CLOCK_50  in  1  single clock; all state updates on its rising edge.
REQ-007 SC_RegLANE_RESET_InHigh  in  1  reset; synchronous, active-high.
REQ-008 SC_RegLANE_clear_InLow  in  1  active-low; loads DATA_FIXED_INITREG.
REQ-009 SC_RegLANE_load_InLow  in  1  active-low; loads data_InBUS.
REQ-010 SC_RegLANE_shiftselection_In  in  2  mode: 00 hold, 01 right, 10 left, 11 rotate-left.
REQ-011 SC_RegLANE_tick_In  in  1  one-cycle movement strobe.
REQ-012 SC_RegLANE_speed_In  in  DIVWIDTH  ticks per step minus one.
REQ-013 SC_RegLANE_data_InBUS  in  DATAWIDTH  parallel load data.
REQ-014 SC_RegLANE_random_InBUS  in  RANDWIDTH  refill pattern.
REQ-015 SC_RegLANE_data_OutBUS  out  OUTWIDTH  register bits [DATAWIDTH-1 : DATAWIDTH-OUTWIDTH].
REQ-016 SC_RegLANE_shifted_Out  out  1  registered one-cycle pulse; a step occurred on the previous edge.
REQ-017 SC_RegLANE_refill_Out  out  1  registered one-cycle pulse; that step inserted random data.

Function
REQ-018 Priority per edge SHALL be: reset > clear > load > step > hold.
REQ-019 Divider counter (DIVWIDTH bits) SHALL increment on each tick_In=1 in modes 01/10/11; a step SHALL occur on a tick when counter==speed_In, and the counter SHALL then return to 0.
REQ-020 speed_In=0 SHALL step on every tick; counter SHALL freeze in mode 00 and when tick_In=0.
REQ-021 If speed_In is lowered below the current count, the counter SHALL count up and wrap modulo 2^DIVWIDTH with no step until equality.
REQ-022 Left step: if bits [RANDWIDTH-1:0]==0, new value SHALL be {reg[DATAWIDTH-2:RANDWIDTH-1], random_InBUS} with refill; else {reg[DATAWIDTH-2:0],1'b0}.
REQ-023 Right step: if bits [DATAWIDTH-1:DATAWIDTH-RANDWIDTH]==0, new value SHALL be {random_InBUS, reg[DATAWIDTH-RANDWIDTH:1]} with refill; else {1'b0, reg[DATAWIDTH-1:1]}.
REQ-024 Rotate step (when compiled in) SHALL be {reg[DATAWIDTH-2:0], reg[DATAWIDTH-1]}; never a refill.
REQ-025 Clear or load SHALL zero the divider counter and suppress both pulses, even on a coincident tick at count equality.
REQ-026 Mode change SHALL NOT reset the counter.
REQ-027 shifted_Out and refill_Out SHALL assert for exactly one cycle, one clock after the step edge; refill_Out implies shifted_Out.

Reset
REQ-028 On a rising edge with reset=1: register=0 (not DATA_FIXED_INITREG), counter=0, data_OutBUS=0, shifted_Out=0, refill_Out=0.
REQ-029 Reset mid-count SHALL discard the partial count; all other inputs are ignored that edge.

Configuration
REQ-030 Macro SC_REGLANE_ROTATE_EN: defined -> mode 11 performs REQ-024; undefined -> mode 11 behaves as mode 00 (hold, counter frozen, no pulses).

Verification
REQ-031 Reset=1 one edge with load_InLow=0 and data 0xFFFF -> data_OutBUS=0x00, both pulses 0.
REQ-032 load_InLow=0, data_InBUS=0xA5F0 -> next cycle data_OutBUS=0xA5.
REQ-033 Reg=0x8001, mode 10, speed_In=2, tick every cycle -> step only on 3rd tick, reg=0x0002, shifted_Out=1, refill_Out=0 for one cycle.
REQ-034 Reg=0x1230, mode 10, speed_In=0, random=0x9, one tick -> reg=0x2469, data_OutBUS=0x24, shifted_Out=1, refill_Out=1.
REQ-035 Reg=0x0F00, mode 01, speed_In=0, random=0xC, one tick -> reg=0xC780, refill_Out=1; clear_InLow=0 on a coincident tick -> reg=DATA_FIXED_INITREG, no pulse.
REQ-036 Reg=0x8001, mode 11, one tick -> with SC_REGLANE_ROTATE_EN reg=0x0003, shifted_Out=1; without, reg holds 0x8001, no pulse.

Source files
------------

// File: rtl/sc_reglane_scroller.sv
`default_nettype none
//==============================================================================
// Module      : sc_reglane_scroller
// Description : Scrolling lane register. A parallel-loadable shift register
//               whose movement (hold / right / left / rotate-left) is paced by
//               a tick strobe and a programmable divider. When a shift would
//               push the register's leading edge field empty, a random
//               refill pattern is inserted instead of zeros.
//
// Ports       : SC_RegLANE_CLOCK_50        clock, rising edge
//               SC_RegLANE_RESET_InHigh    synchronous active-high reset
//               SC_RegLANE_clear_InLow     active-low, load DATA_FIXED_INITREG
//               SC_RegLANE_load_InLow      active-low, load data_InBUS
//               SC_RegLANE_shiftselection_In  00 hold,01 right,10 left,11 rot
//               SC_RegLANE_tick_In         movement strobe
//               SC_RegLANE_speed_In        ticks per step minus one
//               SC_RegLANE_data_InBUS      parallel load data
//               SC_RegLANE_random_InBUS    refill pattern
//               SC_RegLANE_data_OutBUS     top OUTWIDTH bits of the register
//               SC_RegLANE_shifted_Out     pulse: a step happened last edge
//               SC_RegLANE_refill_Out      pulse: that step inserted refill
//
// Build macro : SC_REGLANE_ROTATE_EN -- enables rotate-left in mode 11;
//               without it mode 11 is a second hold mode.
//
// Revision    : 1.0 - initial release
//==============================================================================
module sc_reglane_scroller #(
    parameter int DATAWIDTH  = 16,
    parameter int OUTWIDTH   = 8,
    parameter int RANDWIDTH  = 4,
    parameter int DIVWIDTH   = 4,
    parameter logic [DATAWIDTH-1:0] DATA_FIXED_INITREG = '0
) (
    input  logic                 SC_RegLANE_CLOCK_50,
    input  logic                 SC_RegLANE_RESET_InHigh,
    input  logic                 SC_RegLANE_clear_InLow,
    input  logic                 SC_RegLANE_load_InLow,
    input  logic [1:0]           SC_RegLANE_shiftselection_In,
    input  logic                 SC_RegLANE_tick_In,
    input  logic [DIVWIDTH-1:0]  SC_RegLANE_speed_In,
    input  logic [DATAWIDTH-1:0] SC_RegLANE_data_InBUS,
    input  logic [RANDWIDTH-1:0] SC_RegLANE_random_InBUS,
    output logic [OUTWIDTH-1:0]  SC_RegLANE_data_OutBUS,
    output logic                 SC_RegLANE_shifted_Out,
    output logic                 SC_RegLANE_refill_Out
);

    localparam logic [1:0] c_MODE_HOLD   = 2'b00;
    localparam logic [1:0] c_MODE_RIGHT  = 2'b01;
    localparam logic [1:0] c_MODE_LEFT   = 2'b10;
    localparam logic [1:0] c_MODE_ROTATE = 2'b11;

    logic [DATAWIDTH-1:0] r_laneReg;
    logic [DIVWIDTH-1:0]  r_divCount;
    logic                 r_shifted;
    logic                 r_refill;

    logic                 w_modeActive;
    logic [DATAWIDTH-1:0] w_stepValue;
    logic                 w_stepRefill;

    // Decide which modes move the lane and what one step produces. A mode
    // that is not active freezes the divider as well as the register.
    always_comb begin
        w_modeActive = 1'b0;
        w_stepValue  = r_laneReg;
        w_stepRefill = 1'b0;
        case (SC_RegLANE_shiftselection_In)
            c_MODE_RIGHT: begin
                w_modeActive = 1'b1;
                // Leading (top) field empty: feed the refill pattern in there.
                if (r_laneReg[DATAWIDTH-1:DATAWIDTH-RANDWIDTH] == '0) begin
                    w_stepValue  = {SC_RegLANE_random_InBUS,
                                    r_laneReg[DATAWIDTH-RANDWIDTH:1]};
                    w_stepRefill = 1'b1;
                end else begin
                    w_stepValue  = {1'b0, r_laneReg[DATAWIDTH-1:1]};
                end
            end
            c_MODE_LEFT: begin
                w_modeActive = 1'b1;
                // Trailing (bottom) field empty: refill enters at the bottom.
                if (r_laneReg[RANDWIDTH-1:0] == '0) begin
                    w_stepValue  = {r_laneReg[DATAWIDTH-2:RANDWIDTH-1],
                                    SC_RegLANE_random_InBUS};
                    w_stepRefill = 1'b1;
                end else begin
                    w_stepValue  = {r_laneReg[DATAWIDTH-2:0], 1'b0};
                end
            end
            c_MODE_ROTATE: begin
`ifdef SC_REGLANE_ROTATE_EN
                w_modeActive = 1'b1;
                w_stepValue  = {r_laneReg[DATAWIDTH-2:0],
                                r_laneReg[DATAWIDTH-1]};
`else
                w_modeActive = 1'b0;
`endif
            end
            c_MODE_HOLD: begin
                w_modeActive = 1'b0;
            end
            default: begin
                w_modeActive = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SC_RegLANE_CLOCK_50) begin
        if (SC_RegLANE_RESET_InHigh) begin
            r_laneReg  <= '0;
            r_divCount <= '0;
            r_shifted  <= 1'b0;
            r_refill   <= 1'b0;
        end else begin
            r_shifted <= 1'b0;
            r_refill  <= 1'b0;
            if (!SC_RegLANE_clear_InLow) begin
                r_laneReg  <= DATA_FIXED_INITREG;
                r_divCount <= '0;
            end else if (!SC_RegLANE_load_InLow) begin
                r_laneReg  <= SC_RegLANE_data_InBUS;
                r_divCount <= '0;
            end else if (w_modeActive && SC_RegLANE_tick_In) begin
                // Compare before incrementing: speed N steps on tick N+1.
                // A count already past speed wraps through 2^DIVWIDTH.
                if (r_divCount == SC_RegLANE_speed_In) begin
                    r_divCount <= '0;
                    r_laneReg  <= w_stepValue;
                    r_shifted  <= 1'b1;
                    r_refill   <= w_stepRefill;
                end else begin
                    r_divCount <= r_divCount + DIVWIDTH'(1);
                end
            end
        end
    end

    assign SC_RegLANE_data_OutBUS = r_laneReg[DATAWIDTH-1:DATAWIDTH-OUTWIDTH];
    assign SC_RegLANE_shifted_Out = r_shifted;
    assign SC_RegLANE_refill_Out  = r_refill;

endmodule
`default_nettype wire

// File: tb/tb_sc_reglane_scroller.sv
`default_nettype none
//==============================================================================
// Module      : tb_sc_reglane_scroller
// Description : Directed bench for sc_reglane_scroller. Each driven cycle
//               queues the hand-computed outputs expected after that edge;
//               a monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sc_reglane_scroller;

    localparam logic [15:0] c_INIT = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        clrN;
    logic        ldN;
    logic [1:0]  mode;
    logic        tick;
    logic [3:0]  speed;
    logic [15:0] dataIn;
    logic [3:0]  rnd;
    logic [7:0]  dataOut;
    logic        shiftedOut;
    logic        refillOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       r;
        string      name;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    sc_reglane_scroller #(
        .DATAWIDTH(16), .OUTWIDTH(8), .RANDWIDTH(4), .DIVWIDTH(4),
        .DATA_FIXED_INITREG(c_INIT)
    ) dut (
        .SC_RegLANE_CLOCK_50          (clk),
        .SC_RegLANE_RESET_InHigh      (rst),
        .SC_RegLANE_clear_InLow       (clrN),
        .SC_RegLANE_load_InLow        (ldN),
        .SC_RegLANE_shiftselection_In (mode),
        .SC_RegLANE_tick_In           (tick),
        .SC_RegLANE_speed_In          (speed),
        .SC_RegLANE_data_InBUS        (dataIn),
        .SC_RegLANE_random_InBUS      (rnd),
        .SC_RegLANE_data_OutBUS       (dataOut),
        .SC_RegLANE_shifted_Out       (shiftedOut),
        .SC_RegLANE_refill_Out        (refillOut)
    );

    // Monitor: one queued expectation per completed edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (dataOut !== e.d || shiftedOut !== e.s || refillOut !== e.r) begin
                errors++;
                $display("FAIL %s: got data=%h shifted=%b refill=%b, expected data=%h shifted=%b refill=%b",
                         e.name, dataOut, shiftedOut, refillOut, e.d, e.s, e.r);
            end
        end
    end

    // Drive one cycle of inputs, then queue what must appear after the edge.
    task automatic cyc(input logic r, input logic c, input logic l,
                       input logic [1:0] m, input logic t, input logic [3:0] sp,
                       input logic [15:0] d, input logic [3:0] rn,
                       input logic [7:0] ed, input logic es, input logic er,
                       input string nm);
        exp_t e;
        rst = r; clrN = c; ldN = l; mode = m; tick = t;
        speed = sp; dataIn = d; rnd = rn;
        @(posedge clk);
        e.d = ed; e.s = es; e.r = er; e.name = nm;
        sbq.push_back(e);
        #1;
    endtask

    task automatic load(input logic [15:0] d, input logic [7:0] ed, input string nm);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, d, 4'h0, ed, 1'b0, 1'b0, nm);
    endtask

    task automatic mv(input logic [1:0] m, input logic t, input logic [3:0] sp,
                      input logic [3:0] rn, input logic [7:0] ed,
                      input logic es, input logic er, input string nm);
        cyc(1'b0, 1'b1, 1'b1, m, t, sp, 16'h0000, rn, ed, es, er, nm);
    endtask

    initial begin
        rst = 1'b0; clrN = 1'b1; ldN = 1'b1; mode = 2'b00; tick = 1'b0;
        speed = 4'd0; dataIn = 16'h0; rnd = 4'h0;
        @(posedge clk); #1;

        // Reset dominates a coincident load
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 16'hFFFF, 4'h0, 8'h00, 1'b0, 1'b0, "reset_over_load");
        load(16'hA5F0, 8'hA5, "load_A5F0");
        mv(2'b00, 1'b1, 4'd0, 4'h0, 8'hA5, 1'b0, 1'b0, "hold_mode");

        // Divider speed 2: step on third tick
        load(16'h8001, 8'h80, "load_8001");
        mv(2'b10, 1'b1, 4'd2, 4'h0, 8'h80, 1'b0, 1'b0, "div_tick1");
        mv(2'b10, 1'b1, 4'd2, 4'h0, 8'h80, 1'b0, 1'b0, "div_tick2");
        mv(2'b10, 1'b1, 4'd2, 4'h0, 8'h00, 1'b1, 1'b0, "div_tick3_step");
        mv(2'b10, 1'b0, 4'd2, 4'h0, 8'h00, 1'b0, 1'b0, "pulse_one_cycle");

        // Left refill
        load(16'h1230, 8'h12, "load_1230");
        mv(2'b10, 1'b1, 4'd0, 4'h9, 8'h24, 1'b1, 1'b1, "left_refill");
        mv(2'b00, 1'b0, 4'd0, 4'h9, 8'h24, 1'b0, 1'b0, "left_refill_end");

        // Right refill, then clear on a coincident step tick
        load(16'h0F00, 8'h0F, "load_0F00");
        mv(2'b01, 1'b1, 4'd0, 4'hC, 8'hC7, 1'b1, 1'b1, "right_refill");
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 4'd0, 16'h0, 4'hC, 8'h5A, 1'b0, 1'b0, "clear_over_step");

        // Load at count equality zeroes the divider and suppresses pulses
        load(16'h8001, 8'h80, "load_8001b");
        mv(2'b10, 1'b1, 4'd1, 4'h3, 8'h80, 1'b0, 1'b0, "eq_count1");
        cyc(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 4'd1, 16'h4000, 4'h3, 8'h40, 1'b0, 1'b0, "load_over_step");
        mv(2'b10, 1'b1, 4'd1, 4'h3, 8'h40, 1'b0, 1'b0, "count_restart");
        mv(2'b10, 1'b1, 4'd1, 4'h3, 8'h80, 1'b1, 1'b1, "step_after_load");

        // Mode change keeps the count
        load(16'h0110, 8'h01, "load_0110");
        mv(2'b10, 1'b1, 4'd1, 4'hA, 8'h01, 1'b0, 1'b0, "mode_cnt1");
        mv(2'b01, 1'b1, 4'd1, 4'hA, 8'hA0, 1'b1, 1'b1, "mode_change_step");

        // Reset mid-count discards the partial count
        load(16'h0110, 8'h01, "load_0110b");
        mv(2'b10, 1'b1, 4'd3, 4'h5, 8'h01, 1'b0, 1'b0, "rst_cnt1");
        mv(2'b10, 1'b1, 4'd3, 4'h5, 8'h01, 1'b0, 1'b0, "rst_cnt2");
        cyc(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 4'd2, 16'h0, 4'h5, 8'h00, 1'b0, 1'b0, "reset_midcount");
        mv(2'b10, 1'b1, 4'd2, 4'h5, 8'h00, 1'b0, 1'b0, "post_rst_t1");
        mv(2'b10, 1'b1, 4'd2, 4'h5, 8'h00, 1'b0, 1'b0, "post_rst_t2");
        mv(2'b10, 1'b1, 4'd2, 4'h5, 8'h00, 1'b1, 1'b1, "post_rst_step");

        // Speed lowered below count: wrap through 15 before stepping
        load(16'h0110, 8'h01, "load_0110c");
        for (int i = 0; i < 3; i++)
            mv(2'b10, 1'b1, 4'd3, 4'h0, 8'h01, 1'b0, 1'b0, "wrap_pre");
        for (int i = 0; i < 14; i++)
            mv(2'b10, 1'b1, 4'd1, 4'h0, 8'h01, 1'b0, 1'b0, "wrap_count");
        mv(2'b10, 1'b1, 4'd1, 4'h0, 8'h02, 1'b1, 1'b1, "wrap_step");

        // Mode 11
        load(16'h8001, 8'h80, "load_8001c");
`ifdef SC_REGLANE_ROTATE_EN
        mv(2'b11, 1'b1, 4'd0, 4'hF, 8'h00, 1'b1, 1'b0, "rotate_step");
        mv(2'b11, 1'b0, 4'd0, 4'hF, 8'h00, 1'b0, 1'b0, "rotate_end");
`else
        mv(2'b11, 1'b1, 4'd0, 4'hF, 8'h80, 1'b0, 1'b0, "mode11_hold");
        mv(2'b11, 1'b1, 4'd0, 4'hF, 8'h80, 1'b0, 1'b0, "mode11_hold2");
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
